// File: rtl/ddr_local_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_local_port_arbiter
//  Purpose  : Merges NUM_PORTS local-interface masters onto one DDR controller
//             port with write-burst grant locking and read-return tag steering.
//  Options  : DDR_ARB_FIXED_PRIO_EN - fixed priority (port 0 highest) instead
//             of round-robin arbitration.
//  Revision : 1.0 - initial release
// ============================================================================
module ddr_local_port_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 26,
    parameter int DATA_W    = 128,
    parameter int BE_W      = DATA_W / 8,
    parameter int SIZE_W    = 3,
    parameter int TAG_DEPTH = 8
) (
    input  logic                        phy_clk,
    input  logic                        global_reset_n,
    input  logic [NUM_PORTS-1:0]        p_write_req,
    input  logic [NUM_PORTS-1:0]        p_read_req,
    input  logic [NUM_PORTS*ADDR_W-1:0] p_address,
    input  logic [NUM_PORTS*DATA_W-1:0] p_wdata,
    input  logic [NUM_PORTS*BE_W-1:0]   p_be,
    input  logic [NUM_PORTS*SIZE_W-1:0] p_size,
    output logic [NUM_PORTS-1:0]        p_ready,
    output logic [DATA_W-1:0]           p_rdata,
    output logic [NUM_PORTS-1:0]        p_rdata_valid,
    output logic [ADDR_W-1:0]           local_address,
    output logic                        local_write_req,
    output logic                        local_read_req,
    output logic                        local_burstbegin,
    output logic [DATA_W-1:0]           local_wdata,
    output logic [BE_W-1:0]             local_be,
    output logic [SIZE_W-1:0]           local_size,
    input  logic                        local_ready,
    input  logic [DATA_W-1:0]           local_rdata,
    input  logic                        local_rdata_valid,
    input  logic                        local_init_done,
    output logic                        rd_orphan_err
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int TW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMD    = 2'd1,
        ST_WBURST = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       grant_q, grant_d;
    logic [SIZE_W-1:0]   beat_q, beat_d;

    logic [PW+SIZE_W-1:0] tag_mem_q [TAG_DEPTH];
    logic [TW-1:0]       tag_wr_q, tag_wr_d;
    logic [TW-1:0]       tag_rd_q, tag_rd_d;
    logic [TW:0]         tag_cnt_q, tag_cnt_d;
    logic [SIZE_W-1:0]   rd_beat_q, rd_beat_d;
    logic                orphan_q, orphan_d;

    logic [ADDR_W-1:0]   addr_a  [NUM_PORTS];
    logic [DATA_W-1:0]   wdata_a [NUM_PORTS];
    logic [BE_W-1:0]     be_a    [NUM_PORTS];
    logic [SIZE_W-1:0]   size_a  [NUM_PORTS];

    logic [NUM_PORTS-1:0] req_any;
    logic                found;
    logic [PW-1:0]       pick;
    logic                g_wr, g_rd, rd_cmd;
    logic [SIZE_W-1:0]   g_size, g_size_eff;
    logic                tag_empty, tag_full, push, pop, beat_ok;
    logic [PW+SIZE_W-1:0] tag_head;
    logic [PW-1:0]       head_port;
    logic [SIZE_W-1:0]   head_size, rd_beat_inc;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign addr_a[i]        = p_address[i*ADDR_W +: ADDR_W];
        assign wdata_a[i]       = p_wdata[i*DATA_W +: DATA_W];
        assign be_a[i]          = p_be[i*BE_W +: BE_W];
        assign size_a[i]        = p_size[i*SIZE_W +: SIZE_W];
        assign p_rdata_valid[i] = beat_ok & (head_port == PW'(i));
    end

    assign req_any       = p_write_req | p_read_req;
    assign local_address = addr_a[grant_q];
    assign local_wdata   = wdata_a[grant_q];
    assign local_be      = be_a[grant_q];
    assign local_size    = size_a[grant_q];
    assign g_size        = size_a[grant_q];
    assign g_size_eff    = (g_size == '0) ? SIZE_W'(1) : g_size;
    assign g_wr          = p_write_req[grant_q];
    assign g_rd          = p_read_req[grant_q];
    // A port raising both requests is treated as a write.
    assign rd_cmd        = g_rd & ~g_wr;

`ifdef DDR_ARB_FIXED_PRIO_EN
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_any[i]) begin
                found = 1'b1;
                pick  = PW'(i);
            end
        end
    end
`else
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic          cmd_done;

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!found && req_any[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    assign cmd_done = local_ready &
        (((state_q == ST_CMD) & ((g_wr & (g_size_eff == SIZE_W'(1))) | local_read_req)) |
         ((state_q == ST_WBURST) & g_wr & (beat_q == SIZE_W'(1))));

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (cmd_done) rr_ptr_d = (grant_q == PW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
    end

    always_ff @(posedge phy_clk or negedge global_reset_n) begin
        if (!global_reset_n) rr_ptr_q <= '0;
        else                 rr_ptr_q <= rr_ptr_d;
    end
`endif

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        beat_d           = beat_q;
        local_write_req  = 1'b0;
        local_read_req   = 1'b0;
        local_burstbegin = 1'b0;
        p_ready          = '0;
        push             = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (local_init_done && found) begin
                    grant_d = pick;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                local_burstbegin = 1'b1;
                local_write_req  = g_wr;
                local_read_req   = rd_cmd & ~tag_full;
                p_ready[grant_q] = local_ready & ~(rd_cmd & tag_full);
                if (g_wr && local_ready) begin
                    if (g_size_eff == SIZE_W'(1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d  = g_size_eff - 1'b1;
                        state_d = ST_WBURST;
                    end
                end else if (local_read_req && local_ready) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                end else if (!g_wr && !g_rd) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WBURST: begin
                local_write_req  = g_wr;
                p_ready[grant_q] = local_ready;
                if (g_wr && local_ready) begin
                    beat_d = beat_q - 1'b1;
                    if (beat_q == SIZE_W'(1)) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read return path: beats go to the port at the head of the tag FIFO.
    assign tag_empty   = (tag_cnt_q == '0);
    assign tag_full    = (tag_cnt_q == (TW+1)'(TAG_DEPTH));
    assign tag_head    = tag_mem_q[tag_rd_q];
    assign head_port   = tag_head[SIZE_W +: PW];
    assign head_size   = tag_head[SIZE_W-1:0];
    assign beat_ok     = local_rdata_valid & ~tag_empty;
    assign rd_beat_inc = rd_beat_q + 1'b1;
    assign pop         = beat_ok & (rd_beat_inc == head_size);
    assign p_rdata     = local_rdata;
    assign rd_orphan_err = orphan_q;

    always_comb begin
        tag_wr_d  = push ? tag_wr_q + 1'b1 : tag_wr_q;
        tag_rd_d  = pop ? tag_rd_q + 1'b1 : tag_rd_q;
        tag_cnt_d = tag_cnt_q;
        if (push && !pop) tag_cnt_d = tag_cnt_q + 1'b1;
        if (pop && !push) tag_cnt_d = tag_cnt_q - 1'b1;
        rd_beat_d = rd_beat_q;
        if (beat_ok) rd_beat_d = pop ? '0 : rd_beat_inc;
        orphan_d  = orphan_q | (local_rdata_valid & tag_empty);
    end

    always_ff @(posedge phy_clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            beat_q    <= '0;
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
            tag_cnt_q <= '0;
            rd_beat_q <= '0;
            orphan_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            beat_q    <= beat_d;
            tag_wr_q  <= tag_wr_d;
            tag_rd_q  <= tag_rd_d;
            tag_cnt_q <= tag_cnt_d;
            rd_beat_q <= rd_beat_d;
            orphan_q  <= orphan_d;
        end
    end

    always_ff @(posedge phy_clk) begin
        if (push) tag_mem_q[tag_wr_q] <= {grant_q, g_size_eff};
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr_local_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr_local_port_arbiter
//  Purpose  : Directed and randomized checks of ddr_local_port_arbiter against
//             a transaction-level model (grant owner, tag queue, RR pointer).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_local_port_arbiter;
    localparam int NP = 2;
    localparam int AW = 26;
    localparam int DW = 128;
    localparam int BW = DW / 8;
    localparam int SW = 3;
    localparam int TD = 8;

    logic            phy_clk = 1'b0;
    logic            global_reset_n = 1'b0;
    logic [NP-1:0]   p_write_req = '0;
    logic [NP-1:0]   p_read_req = '0;
    logic [NP*AW-1:0] p_address = '0;
    logic [NP*DW-1:0] p_wdata = '0;
    logic [NP*BW-1:0] p_be = '0;
    logic [NP*SW-1:0] p_size = '0;
    logic [NP-1:0]   p_ready, p_rdata_valid;
    logic [DW-1:0]   p_rdata, local_wdata;
    logic [DW-1:0]   local_rdata = '0;
    logic [AW-1:0]   local_address;
    logic            local_write_req, local_read_req, local_burstbegin;
    logic [BW-1:0]   local_be;
    logic [SW-1:0]   local_size;
    logic            local_ready = 1'b0;
    logic            local_rdata_valid = 1'b0;
    logic            local_init_done = 1'b0;
    logic            rd_orphan_err;

    int vectors = 0;
    int miscompares = 0;

    ddr_local_port_arbiter #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .SIZE_W(SW), .TAG_DEPTH(TD)
    ) dut (
        .phy_clk(phy_clk), .global_reset_n(global_reset_n),
        .p_write_req(p_write_req), .p_read_req(p_read_req), .p_address(p_address),
        .p_wdata(p_wdata), .p_be(p_be), .p_size(p_size), .p_ready(p_ready),
        .p_rdata(p_rdata), .p_rdata_valid(p_rdata_valid),
        .local_address(local_address), .local_write_req(local_write_req),
        .local_read_req(local_read_req), .local_burstbegin(local_burstbegin),
        .local_wdata(local_wdata), .local_be(local_be), .local_size(local_size),
        .local_ready(local_ready), .local_rdata(local_rdata),
        .local_rdata_valid(local_rdata_valid), .local_init_done(local_init_done),
        .rd_orphan_err(rd_orphan_err)
    );

    always #5 phy_clk = ~phy_clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: owner of the grant (-1 = none), remaining burst beats,
    // round-robin pointer, outstanding read tags and beats seen for the head.
    int  m_owner = -1;
    int  m_left = 0;
    int  m_ptr = 0;
    int  m_head = 0;
    bit  m_orphan = 1'b0;
    int  q_port[$];
    int  q_size[$];
    int  cmd_log[$];
    logic [DW-1:0] rx0[$];
    logic [DW-1:0] rx1[$];

    function automatic int eff(input int g);
        int s;
        s = int'(p_size[g*SW +: SW]);
        return (s == 0) ? 1 : s;
    endfunction

    task automatic release_grant(input int g);
        m_owner = -1;
        m_left  = 0;
        m_ptr   = (g + 1) % NP;
    endtask

    always @(negedge phy_clk) begin
        logic [NP-1:0] e_ready, e_rv;
        logic e_wr, e_rd, e_bb, w, r, full;
        int g, idx;
        e_ready = '0; e_rv = '0; e_wr = 1'b0; e_rd = 1'b0; e_bb = 1'b0;
        w = 1'b0; r = 1'b0; full = 1'b0; g = -1; idx = 0;
        if (!global_reset_n) begin
            m_owner = -1; m_left = 0; m_ptr = 0; m_head = 0; m_orphan = 1'b0;
            q_port.delete(); q_size.delete();
            chk("rst_wr", local_write_req, 0);
            chk("rst_rd", local_read_req, 0);
            chk("rst_bb", local_burstbegin, 0);
            chk("rst_ready", p_ready, 0);
            chk("rst_rvalid", p_rdata_valid, 0);
            chk("rst_orphan", rd_orphan_err, 0);
        end else begin
            full = (q_port.size() == TD);
            g = m_owner;
            if (g >= 0) begin
                w = p_write_req[g];
                r = p_read_req[g];
                e_wr = w;
                if (m_left == 0) begin
                    e_bb = 1'b1;
                    e_rd = r && !w && !full;
                    e_ready[g] = local_ready && !(r && !w && full);
                end else begin
                    e_ready[g] = local_ready;
                end
            end
            if (local_rdata_valid && q_port.size() != 0) e_rv[q_port[0]] = 1'b1;
            chk("wr_req", local_write_req, e_wr);
            chk("rd_req", local_read_req, e_rd);
            chk("burstbegin", local_burstbegin, e_bb);
            chk("p_ready", p_ready, e_ready);
            chk("p_rdata_valid", p_rdata_valid, e_rv);
            chk("p_rdata", p_rdata, local_rdata);
            chk("orphan", rd_orphan_err, m_orphan);
            if (g >= 0) begin
                chk("address", local_address, p_address[g*AW +: AW]);
                chk("wdata", local_wdata, p_wdata[g*DW +: DW]);
                chk("be", local_be, p_be[g*BW +: BW]);
                chk("size", local_size, p_size[g*SW +: SW]);
            end
            if (local_ready && (local_write_req || local_read_req))
                cmd_log.push_back((local_write_req ? 100 : 0) + (local_burstbegin ? 10 : 0)
                                  + int'(local_address[3:0]));
            if (p_rdata_valid[0]) rx0.push_back(p_rdata);
            if (p_rdata_valid[1]) rx1.push_back(p_rdata);

            if (local_rdata_valid) begin
                if (q_port.size() == 0) begin
                    m_orphan = 1'b1;
                end else begin
                    m_head++;
                    if (m_head == q_size[0]) begin
                        void'(q_port.pop_front());
                        void'(q_size.pop_front());
                        m_head = 0;
                    end
                end
            end
            if (g < 0) begin
                if (local_init_done) begin
                    for (int k = 0; k < NP; k++) begin
`ifdef DDR_ARB_FIXED_PRIO_EN
                        idx = k;
`else
                        idx = (m_ptr + k) % NP;
`endif
                        if (m_owner < 0 && (p_write_req[idx] || p_read_req[idx])) m_owner = idx;
                    end
                    m_left = 0;
                end
            end else if (m_left == 0) begin
                if (w && local_ready) begin
                    if (eff(g) == 1) release_grant(g);
                    else m_left = eff(g) - 1;
                end else if (r && !full && local_ready) begin
                    q_port.push_back(g);
                    q_size.push_back(eff(g));
                    release_grant(g);
                end else if (!w && !r) begin
                    m_owner = -1;
                end
            end else if (w && local_ready) begin
                m_left--;
                if (m_left == 0) release_grant(g);
            end
        end
    end

    task automatic step();
        @(posedge phy_clk);
        #1;
    endtask

    task automatic idle_inputs();
        p_write_req = '0; p_read_req = '0; p_size = '0; p_address = '0;
        local_ready = 1'b0; local_rdata_valid = 1'b0;
    endtask

    task automatic do_reset();
        global_reset_n = 1'b0;
        idle_inputs();
        repeat (2) step();
        global_reset_n = 1'b1;
    endtask

    task automatic set_port(input int i, input bit w, input bit r, input int sz, input int addr);
        p_write_req[i] = w;
        p_read_req[i]  = r;
        p_size[i*SW +: SW]    = SW'(sz);
        p_address[i*AW +: AW] = AW'(addr);
        p_wdata[i*DW +: DW]   = {$urandom, $urandom, $urandom, $urandom};
        p_be[i*BW +: BW]      = BW'($urandom);
    endtask

    task automatic wait_log(input int n, input int bound);
        int k;
        k = 0;
        while (cmd_log.size() < n && k < bound) begin
            step();
            k++;
        end
        if (cmd_log.size() < n) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_log: got %0d commands, expected %0d", cmd_log.size(), n);
        end
    endtask

    function automatic int log_at(input int k);
        return (k < cmd_log.size()) ? cmd_log[k] : -1;
    endfunction

    initial begin
        int exp_alt[4];
        int k;
`ifdef DDR_ARB_FIXED_PRIO_EN
        exp_alt = '{10, 10, 10, 10};
`else
        exp_alt = '{10, 11, 10, 11};
`endif
        // Calibration gating, then one-cycle grant
        repeat (3) step();
        @(negedge phy_clk);
        chk("t0_orphan", rd_orphan_err, 0);
        step();
        global_reset_n = 1'b1;
        set_port(0, 0, 1, 1, 0);
        repeat (3) step();
        @(negedge phy_clk);
        chk("t1_noinit_rd", local_read_req, 0);
        chk("t1_noinit_rdy", p_ready, 0);
        step();
        local_init_done = 1'b1;
        step();
        @(negedge phy_clk);
        chk("t1_bb", local_burstbegin, 1);
        chk("t1_rd", local_read_req, 1);
        step();
        set_port(0, 0, 0, 1, 0);
        repeat (2) step();

        // Arbitration order with two reading ports
        do_reset();
        cmd_log.delete();
        set_port(0, 0, 1, 1, 0);
        set_port(1, 0, 1, 1, 1);
        local_ready = 1'b1;
        wait_log(4, 20);
        idle_inputs();
        for (int i = 0; i < 4; i++) chk("t2_order", log_at(i), exp_alt[i]);

        // Write burst locking with toggled local_ready
        do_reset();
        cmd_log.delete();
        set_port(1, 1, 0, 4, 1);
        k = 0;
        while (cmd_log.size() < 5 && k < 40) begin
            local_ready = (k % 2 == 1);
            if (cmd_log.size() >= 1 && !p_read_req[0]) set_port(0, 0, 1, 1, 0);
            step();
            k++;
        end
        idle_inputs();
        chk("t3_beat0", log_at(0), 111);
        for (int i = 1; i < 4; i++) chk("t3_beat", log_at(i), 101);
        chk("t3_read_after", log_at(4), 10);

        // Read return steering
        do_reset();
        cmd_log.delete();
        rx0.delete();
        rx1.delete();
        local_ready = 1'b1;
        set_port(0, 0, 1, 2, 0);
        wait_log(1, 10);
        set_port(0, 0, 0, 2, 0);
        set_port(1, 0, 1, 1, 1);
        wait_log(2, 10);
        set_port(1, 0, 0, 1, 1);
        local_rdata_valid = 1'b1;
        local_rdata = 128'hAAAA_0000_0000_0000_0000_0000_0000_000A;
        step();
        local_rdata = 128'hBBBB_0000_0000_0000_0000_0000_0000_000B;
        step();
        local_rdata = 128'hCCCC_0000_0000_0000_0000_0000_0000_000C;
        step();
        local_rdata_valid = 1'b0;
        step();
        chk("t4_rx0_n", rx0.size(), 2);
        chk("t4_rx1_n", rx1.size(), 1);
        if (rx0.size() == 2) begin
            chk("t4_rx0_a", rx0[0], 128'hAAAA_0000_0000_0000_0000_0000_0000_000A);
            chk("t4_rx0_b", rx0[1], 128'hBBBB_0000_0000_0000_0000_0000_0000_000B);
        end
        if (rx1.size() == 1) chk("t4_rx1_c", rx1[0], 128'hCCCC_0000_0000_0000_0000_0000_0000_000C);

        // Tag FIFO full stalls reads but not writes
        do_reset();
        cmd_log.delete();
        local_ready = 1'b1;
        set_port(0, 0, 1, 1, 0);
        wait_log(8, 40);
        repeat (2) step();
        @(negedge phy_clk);
        chk("t5_full_rdy", p_ready[0], 0);
        chk("t5_full_rd", local_read_req, 0);
        step();
        p_write_req[0] = 1'b1;
        wait_log(9, 10);
        p_write_req[0] = 1'b0;
        chk("t5_write", log_at(8), 110);
        local_rdata_valid = 1'b1;
        step();
        local_rdata_valid = 1'b0;
        wait_log(10, 10);
        chk("t5_ninth", log_at(9), 10);

        // Orphan beat
        do_reset();
        local_rdata_valid = 1'b1;
        @(negedge phy_clk);
        chk("t6_rvalid", p_rdata_valid, 0);
        step();
        local_rdata_valid = 1'b0;
        repeat (3) step();
        @(negedge phy_clk);
        chk("t6_orphan", rd_orphan_err, 1);
        step();
        global_reset_n = 1'b0;
        @(negedge phy_clk);
        chk("t6_orphan_clr", rd_orphan_err, 0);
        step();

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NP; i++) begin
                set_port(i, ($urandom % 4 == 0), ($urandom % 3 == 0), int'($urandom % 8),
                         int'($urandom));
            end
            local_ready       = ($urandom % 4 != 0);
            local_rdata       = {$urandom, $urandom, $urandom, $urandom};
            local_rdata_valid = (q_port.size() != 0) ? ($urandom % 2 == 0) : ($urandom % 40 == 0);
            local_init_done   = ($urandom % 50 != 0);
            global_reset_n    = ($urandom % 500 != 0);
            step();
        end
        global_reset_n = 1'b1;
        idle_inputs();
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1);
    end

endmodule
`default_nettype wire
